// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU memory path.
// Imported by the arbiter and its round-robin helper.
package lsu_pkg;

  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef struct packed {
    logic                  rd_en;
    logic                  wr_en;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wr_data;
    mem_size_t             size;
  } lsu_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from rr_ptr.
// The pointer advances past the winner only on a granted cycle.
module rr_arbiter
  import lsu_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;
  logic [IW-1:0] idx;
  logic          found;

  // N is a power of two, so IW-bit addition wraps modulo N
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = rr_ptr_q + IW'(k);
      if (en_i && !found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

  assign rr_ptr_d = found ? grant_idx_o + IW'(1) : rr_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one data-memory port among the LSU slots of a bundle.
// Loads return one cycle after grant, routed by the registered tag.
module lsu_mem_arbiter
  import lsu_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = LSU_ADDR_W,
  parameter int DATA_W    = LSU_DATA_W,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_rd_en,
  input  logic [NUM_PORTS-1:0]          req_wr_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wr_data,
  input  logic [NUM_PORTS*2-1:0]        req_size,
  output logic [NUM_PORTS-1:0]          req_stall,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          mem_rd_en,
  output logic                          mem_wr_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wr_data,
  output logic [1:0]                    mem_size,
  input  logic                          mem_ready,
  input  logic [DATA_W-1:0]             mem_rd_data,
  output logic                          err_conflict,
  output logic [CNT_W-1:0]              conflict_cnt
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_PORTS-1:0] valid;
  logic [NUM_PORTS-1:0] grant;
  logic [IW-1:0]        gidx;
  logic                 gnt;
  logic                 sel_rd;
  mem_size_t            sel_size;

  logic                 rd_pending_q, rd_pending_d;
  logic [IW-1:0]        rd_tag_q, rd_tag_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  assign valid = req_rd_en | req_wr_en;

  rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (valid),
    .en_i        (mem_ready),
    .grant_o     (grant),
    .grant_idx_o (gidx)
  );

  assign gnt    = (|grant) & ~rst;
  // A slot raising both strobes is serviced as a load
  assign sel_rd = gnt & req_rd_en[gidx];

  always_comb begin
    mem_rd_en   = sel_rd;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    sel_size    = SZ_BYTE;
    if (gnt) begin
      mem_wr_en   = req_wr_en[gidx] & ~req_rd_en[gidx];
      mem_addr    = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
      mem_wr_data = req_wr_data[int'(gidx)*DATA_W +: DATA_W];
      sel_size    = mem_size_t'(req_size[int'(gidx)*2 +: 2]);
    end
    mem_size = sel_size;
  end

  assign req_stall = rst ? '0 : (valid & ~grant);
  assign rsp_data  = rst ? '0 : mem_rd_data;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      rsp_valid[i] = rd_pending_q & ~rst & (rd_tag_q == IW'(i));
  end

  always_comb begin
    rd_pending_d = sel_rd;
    rd_tag_d     = sel_rd ? gidx : rd_tag_q;
    err_d        = err_q | (|(req_rd_en & req_wr_en));
    cnt_d        = cnt_q;
    if ($countones(valid) > 1 && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending_q <= 1'b0;
      rd_tag_q     <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_tag_q     <= rd_tag_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign err_conflict = err_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter with a cycle-level reference model.
// Counter width is narrowed so saturation is reachable quickly.
module tb_lsu_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_rd_en = '0;
  logic [N-1:0]    req_wr_en = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wr_data = '0;
  logic [N*2-1:0]  req_size = '0;
  logic [N-1:0]    req_stall;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            mem_rd_en;
  logic            mem_wr_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wr_data;
  logic [1:0]      mem_size;
  logic            mem_ready = 1'b0;
  logic [DW-1:0]   mem_rd_data = '0;
  logic            err_conflict;
  logic [CW-1:0]   conflict_cnt;

  int tests = 0;
  int fails = 0;

  lsu_mem_arbiter #(
    .NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_rd_en    (req_rd_en),
    .req_wr_en    (req_wr_en),
    .req_addr     (req_addr),
    .req_wr_data  (req_wr_data),
    .req_size     (req_size),
    .req_stall    (req_stall),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_size     (mem_size),
    .mem_ready    (mem_ready),
    .mem_rd_data  (mem_rd_data),
    .err_conflict (err_conflict),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: next slot to favour, outstanding load, flags
  int m_rr   = 0;
  bit m_pend = 0;
  int m_tag  = 0;
  bit m_err  = 0;
  int m_cnt  = 0;

  function automatic int nvalid();
    int c = 0;
    for (int i = 0; i < N; i++)
      if (req_rd_en[i] || req_wr_en[i]) c++;
    return c;
  endfunction

  function automatic int mgrant();
    int j;
    if (rst || !mem_ready) return -1;
    for (int k = 0; k < N; k++) begin
      j = (m_rr + k) % N;
      if (req_rd_en[j] || req_wr_en[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rr   <= 0;
      m_pend <= 0;
      m_tag  <= 0;
      m_err  <= 0;
      m_cnt  <= 0;
    end else begin
      if (mgrant() >= 0) m_rr <= (mgrant() + 1) % N;
      m_pend <= (mgrant() >= 0) && req_rd_en[mgrant()];
      if ((mgrant() >= 0) && req_rd_en[mgrant()]) m_tag <= mgrant();
      if ((req_rd_en & req_wr_en) != '0) m_err <= 1;
      if (nvalid() >= 2 && m_cnt < (1 << CW) - 1) m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int g;
    logic [N-1:0] e_stall;
    logic [N-1:0] e_rsp;
    g = mgrant();
    e_stall = '0;
    e_rsp   = '0;
    for (int i = 0; i < N; i++)
      if (!rst && (req_rd_en[i] || req_wr_en[i]) && i != g) e_stall[i] = 1'b1;
    if (!rst && m_pend) e_rsp[m_tag] = 1'b1;
    chk("req_stall", 64'(req_stall), 64'(e_stall));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    if (e_rsp != '0) chk("rsp_data", 64'(rsp_data), 64'(mem_rd_data));
    if (g >= 0) begin
      chk("mem_rd_en", 64'(mem_rd_en), 64'(req_rd_en[g]));
      chk("mem_wr_en", 64'(mem_wr_en), 64'(req_wr_en[g] & ~req_rd_en[g]));
      chk("mem_addr", 64'(mem_addr), 64'(req_addr[g*AW +: AW]));
      chk("mem_wr_data", 64'(mem_wr_data), 64'(req_wr_data[g*DW +: DW]));
      chk("mem_size", 64'(mem_size), 64'(req_size[g*2 +: 2]));
    end else begin
      chk("mem_idle", 64'({mem_rd_en, mem_wr_en, mem_size}), 64'(0));
      chk("mem_idle_addr", 64'(mem_addr), 64'(0));
    end
    chk("err_conflict", 64'(err_conflict), 64'(m_err));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
  endtask

  always @(negedge clk) begin
    #2;
    compare_all();
  end

  task automatic set(input logic [1:0] rd, input logic [1:0] wr,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic rdy);
    req_rd_en   = rd;
    req_wr_en   = wr;
    req_addr    = {a1, a0};
    req_wr_data = {32'hB0B0_0000 | a1, 32'hA0A0_0000 | a0};
    req_size    = {2'b10, 2'b01};
    mem_ready   = rdy;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    // Reset holds every output low even with requests present
    set(2'b11, 2'b00, 32'h4, 32'h8, 1'b1);
    repeat (2) nxt();
    #3;
    chk("lit_rst_stall", 64'(req_stall), 64'(0));
    chk("lit_rst_mem_rd", 64'(mem_rd_en), 64'(0));
    chk("lit_rst_rsp", 64'(rsp_valid), 64'(0));
    nxt();
    rst = 1'b0;

    // Single load
    set(2'b01, 2'b00, 32'h100, 32'h0, 1'b1);
    #3;
    chk("lit_load_rd", 64'(mem_rd_en), 64'(1));
    chk("lit_load_addr", 64'(mem_addr), 64'h100);
    chk("lit_load_stall", 64'(req_stall), 64'(0));
    nxt();
    set(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    mem_rd_data = 32'hDEADBEEF;
    #3;
    chk("lit_load_rsp", 64'(rsp_valid), 64'b01);
    chk("lit_load_data", 64'(rsp_data), 64'hDEADBEEF);
    nxt();

    // Fresh pointer for contention
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set(2'b00, 2'b11, 32'h10, 32'h20, 1'b1);
      #3;
      chk("lit_rr_stall", 64'(req_stall), (c % 2 == 0) ? 64'b10 : 64'b01);
      chk("lit_rr_addr", 64'(mem_addr), (c % 2 == 0) ? 64'h10 : 64'h20);
      nxt();
    end
    set(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    #3;
    chk("lit_cnt4", 64'(conflict_cnt), 64'd4);
    nxt();

    // Backpressure on a slot1 load
    for (int c = 0; c < 3; c++) begin
      set(2'b10, 2'b00, 32'h0, 32'h340, 1'b0);
      #3;
      chk("lit_bp_stall", 64'(req_stall), 64'b10);
      chk("lit_bp_rd", 64'(mem_rd_en), 64'(0));
      nxt();
    end
    set(2'b10, 2'b00, 32'h0, 32'h340, 1'b1);
    #3;
    chk("lit_bp_go", 64'(mem_addr), 64'h340);
    nxt();
    set(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    mem_rd_data = 32'hCAFE0001;
    #3;
    chk("lit_bp_rsp", 64'(rsp_valid), 64'b10);
    nxt();

    // Back-to-back loads from alternating slots
    set(2'b01, 2'b00, 32'h200, 32'h0, 1'b1);
    nxt();
    set(2'b10, 2'b00, 32'h0, 32'h300, 1'b1);
    mem_rd_data = 32'h11111111;
    #3;
    chk("lit_b2b_rsp0", 64'(rsp_valid), 64'b01);
    chk("lit_b2b_d0", 64'(rsp_data), 64'h11111111);
    nxt();
    set(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    mem_rd_data = 32'h22222222;
    #3;
    chk("lit_b2b_rsp1", 64'(rsp_valid), 64'b10);
    chk("lit_b2b_d1", 64'(rsp_data), 64'h22222222);
    nxt();

    // Saturate the narrowed conflict counter
    for (int c = 0; c < 12; c++) begin
      set(2'b00, 2'b11, 32'h10, 32'h20, c[0]);
      nxt();
    end
    set(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    #3;
    chk("lit_cnt_sat", 64'(conflict_cnt), 64'd15);
    nxt();

    // Malformed request on slot1
    set(2'b10, 2'b10, 32'h0, 32'h480, 1'b1);
    #3;
    chk("lit_bad_rd", 64'(mem_rd_en), 64'(1));
    chk("lit_bad_wr", 64'(mem_wr_en), 64'(0));
    nxt();
    set(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    #3;
    chk("lit_bad_err", 64'(err_conflict), 64'(1));
    nxt();
    nxt();

    // Async reset between a grant edge and its response
    set(2'b01, 2'b00, 32'h500, 32'h0, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("lit_arst_rsp", 64'(rsp_valid), 64'(0));
    chk("lit_arst_err", 64'(err_conflict), 64'(0));
    chk("lit_arst_cnt", 64'(conflict_cnt), 64'(0));
    nxt();
    rst = 1'b0;
    set(2'b11, 2'b00, 32'h600, 32'h700, 1'b1);
    #3;
    chk("lit_arst_first", 64'(mem_addr), 64'h600);
    nxt();
    set(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    repeat (2) nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Shares one data-memory port between NUM_PORTS LSU execute slots of the VLIW bundle.
- Each slot issues at most one load or store per cycle. The arbiter grants one per cycle in round-robin order and stalls the losers.
- Load data returns one cycle after issue and is routed back to the slot that issued the load.
- Sits between the LSU execute stages and the data-memory interface.

Parameters:
- NUM_PORTS, 2, number of LSU slots; must be ≥2 and a power of two.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- CNT_W, 16, width of the conflict-cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_rd_en  in  NUM_PORTS  per-slot load request.
- req_wr_en  in  NUM_PORTS  per-slot store request.
- req_addr  in  NUM_PORTS*ADDR_W  per-slot address; slot i occupies bits [i*ADDR_W +: ADDR_W].
- req_wr_data  in  NUM_PORTS*DATA_W  per-slot store data.
- req_size  in  NUM_PORTS*2  per-slot access size (00 byte, 01 half, 10 word).
- req_stall  out  NUM_PORTS  request not accepted this cycle; slot holds all request inputs stable.
- rsp_valid  out  NUM_PORTS  load data valid for that slot.
- rsp_data  out  DATA_W  load data; meaningful only where rsp_valid=1.
- mem_rd_en  out  1  memory read strobe.
- mem_wr_en  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wr_data  out  DATA_W  memory write data.
- mem_size  out  2  memory access size.
- mem_ready  in  1  memory can accept an access this cycle.
- mem_rd_data  in  DATA_W  read data, valid the cycle after an accepted mem_rd_en.
- err_conflict  out  1  sticky flag: some slot asserted rd_en and wr_en together.
- conflict_cnt  out  CNT_W  count of cycles with ≥2 valid requests.

Behaviour:
- Reset (async, rst=1): rr_ptr=0, rd_pending=0, rd_tag=0, err_conflict=0, conflict_cnt=0. Every output is forced to 0, including rsp_valid and mem_*; req_stall is also 0.
- Valid request: slot i is valid when req_rd_en[i] | req_wr_en[i].
- Malformed request: both rd_en and wr_en high on a slot sets err_conflict, which stays set until reset. That slot is treated as a load.
- Grant (combinational): if mem_ready=1, grant the first valid slot searching from rr_ptr upward, wrapping modulo NUM_PORTS. If mem_ready=0, nothing is granted.
- Memory drive: mem_* are driven combinationally from the granted slot. With no grant, all mem_* are 0.
- Stall: req_stall[i] = valid[i] & ~grant[i]. Invalid slots never stall.
- Round-robin update: at the posedge with a grant, rr_ptr ← granted+1 (mod NUM_PORTS). With no grant, rr_ptr holds.
- Read tracking:
  - A granted load sets rd_pending←1 and rd_tag←granted at the posedge.
  - Otherwise rd_pending←0.
- Response: rsp_valid = onehot(rd_tag) & {NUM_PORTS{rd_pending}}; rsp_data = mem_rd_data combinationally. Load latency is exactly 1 cycle from the grant cycle.
- Back-to-back loads: a new load may be granted in the same cycle a response returns; responses never overlap.
- Stores produce no response.
- Conflict counter: increments when ≥2 slots are valid, regardless of mem_ready. It saturates at all-ones; no wrap.
- Sustained mem_ready=0: all valid slots stall and rr_ptr holds. A pending response still completes, because memory has already accepted that read.
- Reset mid-operation: a pending response is dropped; rsp_valid=0 immediately.

Decomposition:
- Shared package lsu_pkg:
  - typedef mem_size_t (2-bit enum SZ_BYTE/SZ_HALF/SZ_WORD).
  - constants LSU_ADDR_W=32, LSU_DATA_W=32.
  - struct lsu_req_t {rd_en, wr_en, addr, wr_data, size}. The top level may flatten it at the port boundary.
- Sub-module rr_arbiter, parameterized by N:
  - Inputs: req[N], en (=mem_ready), clk, rst.
  - Outputs: grant one-hot, grant_idx.
  - Owns rr_ptr. Reusable for future shared ports.

Test Plan:
- Single load: slot0 rd_en, addr=0x100, mem_ready=1; mem_rd_data=0xDEADBEEF next cycle → mem_rd_en=1, mem_addr=0x100, req_stall=00; next cycle rsp_valid=01, rsp_data=0xDEADBEEF.
- Contention and round-robin: both slots store every cycle for 4 cycles (addr 0x10/0x20) → grants alternate 0,1,0,1; req_stall alternates 10,01; conflict_cnt=4.
- Backpressure: mem_ready=0 for 3 cycles with slot1 load pending → req_stall[1]=1 for 3 cycles, mem_rd_en=0, rr_ptr unchanged. On ready, slot1 is granted and rsp_valid=10 one cycle later.
- Back-to-back loads: slot0 then slot1 loads on consecutive granted cycles → rsp_valid=01 then 10 on consecutive cycles, with each slot receiving its own data.
- Malformed request: slot1 rd_en=wr_en=1 → err_conflict=1, which stays set after the requests drop; the access appears as mem_rd_en=1, mem_wr_en=0.
- Async reset mid-load: rst asserted between the grant edge and the response cycle → rsp_valid=0 immediately, err_conflict=0, conflict_cnt=0; after release the first grant goes to slot0.
